e203_exu_oitf_trk: RTL and testbench
====================================

# e203_exu_oitf_trk

Outstanding Instruction Track FIFO (OITF) for the E203 execution unit. It records every long-pipe instruction (LSU load/store, NICE) at dispatch. It returns the oldest entry's retire information (`oitf_ret_*`, `oitf_empty`) to the long-pipe writeback stage, and it flags register hazards for the dispatch stage. It sits between dispatch (upstream) and long-pipe writeback (downstream), which consumes its retire outputs.

## Interface
Parameters:
- `OITF_DEPTH`, 2: number of entries; power of two, ≥2.
- `PTR_W`, 1: pointer width, equal to log2(`OITF_DEPTH`).

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `dis_ena`  in  1  allocate an entry at `dis_ptr` this cycle.
- `dis_ready`  out  1  FIFO not full.
- `dis_ptr`  out  PTR_W  index of the next entry to allocate; dispatch tags the instruction (itag) with it.
- `ret_ena`  in  1  retire (pop) the oldest entry this cycle.
- `ret_ptr`  out  PTR_W  index of the oldest entry.
- `ret_rdidx`  out  5  oldest entry's rd index.
- `ret_rdwen`  out  1  oldest entry writes rd.
- `ret_rdfpu`  out  1  oldest entry's rd is an FPU register.
- `ret_pc`  out  32  oldest entry's PC.
- `oitf_empty`  out  1  no valid entries.
- `disp_i_rs1en`, `disp_i_rs2en`, `disp_i_rs3en`, `disp_i_rdwen`  in  1 each  operand enables of the instruction being dispatched.
- `disp_i_rs1fpu`, `disp_i_rs2fpu`, `disp_i_rs3fpu`, `disp_i_rdfpu`  in  1 each  register-file selects of the operands.
- `disp_i_rs1idx`, `disp_i_rs2idx`, `disp_i_rs3idx`, `disp_i_rdidx`  in  5 each  operand indices.
- `disp_i_pc`  in  32  PC of the dispatched instruction.
- `oitfrd_match_disprs1`, `oitfrd_match_disprs2`, `oitfrd_match_disprs3`, `oitfrd_match_disprd`  out  1 each  hazard flags.

## Operation
- Circular buffer state: `OITF_DEPTH` entries, each holding {vld, rdidx, rdwen, rdfpu, pc}. Write pointer `dis_ptr` and read pointer `ret_ptr`, each with a wrap flag.
- Empty and full:
  - empty: pointers equal and wrap flags equal.
  - full: pointers equal and wrap flags differ.
  - `dis_ready` = ~full; `oitf_empty` = empty.
- Effective push: `dis_ena & dis_ready`.
  - Writes `disp_i_rdidx`, `disp_i_rdwen`, `disp_i_rdfpu` and `disp_i_pc` into entry[`dis_ptr`] and sets its vld.
  - Increments `dis_ptr`. On wrapping from `OITF_DEPTH-1` to 0, toggles the write wrap flag.
  - `dis_ena` while full is ignored: no state change.
- Effective pop: `ret_ena & ~oitf_empty`.
  - Clears vld of entry[`ret_ptr`] and increments `ret_ptr` with the same wrap rule.
  - `ret_ena` while empty is ignored.
- Simultaneous push and pop in one cycle are both honoured. Gating uses the registered empty/full state:
  - When full, the push is dropped even though a pop occurs.
  - When empty, the pop is dropped even though a push occurs.
- `ret_rdidx`, `ret_rdwen`, `ret_rdfpu`, `ret_pc` are combinational reads of entry[`ret_ptr`]. They are meaningful only when `oitf_empty` = 0.
- Hazard match, combinational:
  - `oitfrd_match_disprsN` = `disp_i_rsNen` AND some entry i has vld_i & rdwen_i & (rdidx_i == `disp_i_rsNidx`) & (rdfpu_i == `disp_i_rsNfpu`).
  - `oitfrd_match_disprd` uses `disp_i_rdwen`, `disp_i_rdidx` and `disp_i_rdfpu` the same way.
  - Index x0 is not excluded; dispatch masks it.

## Timing
- Reset values: pointers 0, wrap flags 0, all vld 0, all payload 0.
  - `oitf_empty`=1, `dis_ready`=1, `dis_ptr`=0, `ret_ptr`=0, `ret_*`=0, all match flags 0.
- Push latency: entry becomes valid at the next rising edge.
  - `oitf_empty` falls, and the new entry participates in matching, starting the cycle after `dis_ena`.
  - A same-cycle dispatch never matches itself.
- Pop latency: the retiring entry still drives `ret_*` and still matches during the `ret_ena` cycle. It is gone from the next cycle.
- `dis_ptr` and `ret_ptr` are registered values. They are stable for the whole cycle and change only at the clock edge.
- Reset asserted mid-operation clears all state asynchronously. All outputs return to their reset values without waiting for a clock edge.
- No combinational path from `dis_ena` or `ret_ena` to any output.

## Test plan
- Reset: hold `rst_n`=0, then release → `oitf_empty`=1, `dis_ready`=1, `dis_ptr`=0, `ret_ptr`=0, all matches 0.
- Fill to full (depth 2):
  - Push pc=0x80000000 rd=5, then pc=0x80000004 rd=6 → `dis_ready`=0, `ret_ptr`=0, `ret_pc`=0x80000000, `ret_rdidx`=5.
  - A third `dis_ena` → no change.
- Retire in order: pop once → `ret_pc`=0x80000004, `ret_ptr`=1. Pop again → `oitf_empty`=1. `ret_ena` while empty → no change.
- Wrap-around with simultaneous events:
  - With 1 entry, push and pop in the same cycle repeatedly for 8 cycles → occupancy stays 1, pointers cycle 0→1→0, wrap flags toggle, `dis_ready`=1 throughout.
  - Full plus push and pop in the same cycle → only the pop takes effect.
- Hazard: entry holds rd=10, rdwen=1, rdfpu=0.
  - rs1en=1, rs1idx=10, rs1fpu=0 → `oitfrd_match_disprs1`=1.
  - Same with rs1fpu=1 → 0.
  - rdwen=0 in the entry → 0.
  - rs2en=0 with rs2idx=10 → `oitfrd_match_disprs2`=0.
- Reset mid-operation: with 2 entries valid, pulse `rst_n` low between clock edges → outputs return to reset values immediately, and the next push lands at `dis_ptr`=0.

Source files
------------

// File: rtl/e203_exu_oitf_trk.sv
// Outstanding instruction track FIFO: records long-pipe instructions at dispatch,
// presents the oldest entry for writeback and flags rd hazards against dispatch.
module e203_exu_oitf_trk #(
    parameter int OITF_DEPTH = 2,
    parameter int PTR_W      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dis_ena,
    output logic             dis_ready,
    output logic [PTR_W-1:0] dis_ptr,
    input  logic             ret_ena,
    output logic [PTR_W-1:0] ret_ptr,
    output logic [4:0]       ret_rdidx,
    output logic             ret_rdwen,
    output logic             ret_rdfpu,
    output logic [31:0]      ret_pc,
    output logic             oitf_empty,
    input  logic             disp_i_rs1en,
    input  logic             disp_i_rs2en,
    input  logic             disp_i_rs3en,
    input  logic             disp_i_rdwen,
    input  logic             disp_i_rs1fpu,
    input  logic             disp_i_rs2fpu,
    input  logic             disp_i_rs3fpu,
    input  logic             disp_i_rdfpu,
    input  logic [4:0]       disp_i_rs1idx,
    input  logic [4:0]       disp_i_rs2idx,
    input  logic [4:0]       disp_i_rs3idx,
    input  logic [4:0]       disp_i_rdidx,
    input  logic [31:0]      disp_i_pc,
    output logic             oitfrd_match_disprs1,
    output logic             oitfrd_match_disprs2,
    output logic             oitfrd_match_disprs3,
    output logic             oitfrd_match_disprd
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OITF_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0]      wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s;
    logic                  wflg_r, rflg_r, wflg_nxt_s, rflg_nxt_s;
    logic [OITF_DEPTH-1:0] vld_r, rdwen_r, rdfpu_r, live_s;
    logic [4:0]            rdidx_r [OITF_DEPTH];
    logic [31:0]           pc_r    [OITF_DEPTH];
    logic                  empty_s, full_s, push_s, pop_s;
    logic [OITF_DEPTH-1:0] rs1_hit_s, rs2_hit_s, rs3_hit_s, rd_hit_s;

    // Gating relies only on registered pointer state, so enables never reach outputs.
    assign empty_s = (wptr_r == rptr_r) & (wflg_r == rflg_r);
    assign full_s  = (wptr_r == rptr_r) & (wflg_r != rflg_r);
    assign push_s  = dis_ena & ~full_s;
    assign pop_s   = ret_ena & ~empty_s;

    // Next pointer values with wrap-flag toggle on rollover.
    always_comb begin
        wptr_nxt_s = wptr_r;
        wflg_nxt_s = wflg_r;
        rptr_nxt_s = rptr_r;
        rflg_nxt_s = rflg_r;
        if (push_s) begin
            if (wptr_r == PTR_LAST) begin
                wptr_nxt_s = '0;
                wflg_nxt_s = ~wflg_r;
            end else begin
                wptr_nxt_s = wptr_r + PTR_ONE;
            end
        end else begin
            wptr_nxt_s = wptr_r;
        end
        if (pop_s) begin
            if (rptr_r == PTR_LAST) begin
                rptr_nxt_s = '0;
                rflg_nxt_s = ~rflg_r;
            end else begin
                rptr_nxt_s = rptr_r + PTR_ONE;
            end
        end else begin
            rptr_nxt_s = rptr_r;
        end
    end

    // Pointer and wrap-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= '0;
            rptr_r <= '0;
            wflg_r <= 1'b0;
            rflg_r <= 1'b0;
        end else begin
            wptr_r <= wptr_nxt_s;
            rptr_r <= rptr_nxt_s;
            wflg_r <= wflg_nxt_s;
            rflg_r <= rflg_nxt_s;
        end
    end

    // Entry storage; push and pop never target the same slot in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r   <= '0;
            rdwen_r <= '0;
            rdfpu_r <= '0;
            for (int i = 0; i < OITF_DEPTH; i++) begin
                rdidx_r[i] <= 5'd0;
                pc_r[i]    <= 32'd0;
            end
        end else begin
            if (pop_s) begin
                vld_r[rptr_r] <= 1'b0;
            end
            if (push_s) begin
                vld_r[wptr_r]   <= 1'b1;
                rdwen_r[wptr_r] <= disp_i_rdwen;
                rdfpu_r[wptr_r] <= disp_i_rdfpu;
                rdidx_r[wptr_r] <= disp_i_rdidx;
                pc_r[wptr_r]    <= disp_i_pc;
            end
        end
    end

    assign live_s = vld_r & rdwen_r;

    // Per-entry hazard comparison against each dispatched operand.
    always_comb begin
        rs1_hit_s = '0;
        rs2_hit_s = '0;
        rs3_hit_s = '0;
        rd_hit_s  = '0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            rs1_hit_s[i] = live_s[i] & (rdidx_r[i] == disp_i_rs1idx) & (rdfpu_r[i] == disp_i_rs1fpu);
            rs2_hit_s[i] = live_s[i] & (rdidx_r[i] == disp_i_rs2idx) & (rdfpu_r[i] == disp_i_rs2fpu);
            rs3_hit_s[i] = live_s[i] & (rdidx_r[i] == disp_i_rs3idx) & (rdfpu_r[i] == disp_i_rs3fpu);
            rd_hit_s[i]  = live_s[i] & (rdidx_r[i] == disp_i_rdidx)  & (rdfpu_r[i] == disp_i_rdfpu);
        end
    end

    assign oitfrd_match_disprs1 = disp_i_rs1en & (|rs1_hit_s);
    assign oitfrd_match_disprs2 = disp_i_rs2en & (|rs2_hit_s);
    assign oitfrd_match_disprs3 = disp_i_rs3en & (|rs3_hit_s);
    assign oitfrd_match_disprd  = disp_i_rdwen & (|rd_hit_s);

    assign dis_ready  = ~full_s;
    assign oitf_empty = empty_s;
    assign dis_ptr    = wptr_r;
    assign ret_ptr    = rptr_r;
    assign ret_rdidx  = rdidx_r[rptr_r];
    assign ret_rdwen  = rdwen_r[rptr_r];
    assign ret_rdfpu  = rdfpu_r[rptr_r];
    assign ret_pc     = pc_r[rptr_r];

endmodule

// File: tb/tb_e203_exu_oitf_trk.sv
// Directed bench for e203_exu_oitf_trk at depth 2: reset, fill, retire,
// wrap-around with simultaneous push/pop, hazard flags and asynchronous reset.
module tb_e203_exu_oitf_trk;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dis_ena = 1'b0, ret_ena = 1'b0;
    logic        dis_ready, oitf_empty, ret_rdwen, ret_rdfpu;
    logic [0:0]  dis_ptr, ret_ptr;
    logic [4:0]  ret_rdidx;
    logic [31:0] ret_pc;
    logic        rs1en = 1'b0, rs2en = 1'b0, rs3en = 1'b0, rdwen = 1'b0;
    logic        rs1fpu = 1'b0, rs2fpu = 1'b0, rs3fpu = 1'b0, rdfpu = 1'b0;
    logic [4:0]  rs1idx = 5'd0, rs2idx = 5'd0, rs3idx = 5'd0, rdidx = 5'd0;
    logic [31:0] pc = 32'd0;
    logic        m_rs1, m_rs2, m_rs3, m_rd;
    int          checks = 0;
    int          errors = 0;

    e203_exu_oitf_trk #(.OITF_DEPTH(2), .PTR_W(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
        .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdidx(ret_rdidx),
        .ret_rdwen(ret_rdwen), .ret_rdfpu(ret_rdfpu), .ret_pc(ret_pc),
        .oitf_empty(oitf_empty),
        .disp_i_rs1en(rs1en), .disp_i_rs2en(rs2en), .disp_i_rs3en(rs3en), .disp_i_rdwen(rdwen),
        .disp_i_rs1fpu(rs1fpu), .disp_i_rs2fpu(rs2fpu), .disp_i_rs3fpu(rs3fpu), .disp_i_rdfpu(rdfpu),
        .disp_i_rs1idx(rs1idx), .disp_i_rs2idx(rs2idx), .disp_i_rs3idx(rs3idx), .disp_i_rdidx(rdidx),
        .disp_i_pc(pc),
        .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2),
        .oitfrd_match_disprs3(m_rs3), .oitfrd_match_disprd(m_rd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] p, input logic [4:0] rd, input logic wen);
        pc = p; rdidx = rd; rdwen = wen; rdfpu = 1'b0; dis_ena = 1'b1;
        tick();
        dis_ena = 1'b0; rdwen = 1'b0;
    endtask

    task automatic pop();
        ret_ena = 1'b1;
        tick();
        ret_ena = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rs1en = 1'b1; rs2en = 1'b1; rs3en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", oitf_empty); end
        checks++; if (dis_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", dis_ready); end
        rst_n = 1'b1;
        tick();
        checks++; if (dis_ptr !== 1'b0) begin errors++; $display("FAIL rst_dis_ptr got %0d exp 0", dis_ptr); end
        checks++; if (ret_ptr !== 1'b0) begin errors++; $display("FAIL rst_ret_ptr got %0d exp 0", ret_ptr); end
        checks++; if (ret_pc !== 32'd0 || ret_rdidx !== 5'd0 || ret_rdwen !== 1'b0 || ret_rdfpu !== 1'b0) begin
            errors++; $display("FAIL rst_ret got pc=%h rd=%0d exp 0", ret_pc, ret_rdidx); end
        checks++; if ({m_rs1, m_rs2, m_rs3, m_rd} !== 4'b0000) begin
            errors++; $display("FAIL rst_match got %b exp 0000", {m_rs1, m_rs2, m_rs3, m_rd}); end
        checks++; if (oitf_empty !== 1'b1 || dis_ready !== 1'b1) begin
            errors++; $display("FAIL rst_post got empty=%b ready=%b exp 1 1", oitf_empty, dis_ready); end
        rs1en = 1'b0; rs2en = 1'b0; rs3en = 1'b0;
    endtask

    task automatic test_fill();
        push(32'h8000_0000, 5'd5, 1'b1);
        checks++; if (oitf_empty !== 1'b0 || dis_ready !== 1'b1 || dis_ptr !== 1'b1) begin
            errors++; $display("FAIL fill1 got empty=%b ready=%b dptr=%0d exp 0 1 1", oitf_empty, dis_ready, dis_ptr); end
        push(32'h8000_0004, 5'd6, 1'b1);
        checks++; if (dis_ready !== 1'b0 || ret_ptr !== 1'b0 || dis_ptr !== 1'b0) begin
            errors++; $display("FAIL fill2 got ready=%b rptr=%0d dptr=%0d exp 0 0 0", dis_ready, ret_ptr, dis_ptr); end
        checks++; if (ret_pc !== 32'h8000_0000 || ret_rdidx !== 5'd5 || ret_rdwen !== 1'b1) begin
            errors++; $display("FAIL fill2_ret got pc=%h rd=%0d wen=%b exp 80000000 5 1", ret_pc, ret_rdidx, ret_rdwen); end
        push(32'hDEAD_0000, 5'd7, 1'b1);
        checks++; if (dis_ready !== 1'b0 || dis_ptr !== 1'b0 || ret_pc !== 32'h8000_0000) begin
            errors++; $display("FAIL fill_over got ready=%b dptr=%0d pc=%h exp 0 0 80000000", dis_ready, dis_ptr, ret_pc); end
        rs1en = 1'b1; rs1idx = 5'd7; #1;
        checks++; if (m_rs1 !== 1'b0) begin errors++; $display("FAIL fill_over_match got %b exp 0", m_rs1); end
        rs1en = 1'b0;
    endtask

    task automatic test_retire();
        pop();
        checks++; if (ret_pc !== 32'h8000_0004 || ret_ptr !== 1'b1 || ret_rdidx !== 5'd6) begin
            errors++; $display("FAIL ret1 got pc=%h rptr=%0d rd=%0d exp 80000004 1 6", ret_pc, ret_ptr, ret_rdidx); end
        checks++; if (dis_ready !== 1'b1 || oitf_empty !== 1'b0) begin
            errors++; $display("FAIL ret1_flags got ready=%b empty=%b exp 1 0", dis_ready, oitf_empty); end
        pop();
        checks++; if (oitf_empty !== 1'b1 || ret_ptr !== 1'b0 || dis_ptr !== 1'b0) begin
            errors++; $display("FAIL ret2 got empty=%b rptr=%0d dptr=%0d exp 1 0 0", oitf_empty, ret_ptr, dis_ptr); end
        pop();
        checks++; if (oitf_empty !== 1'b1 || ret_ptr !== 1'b0 || dis_ready !== 1'b1) begin
            errors++; $display("FAIL ret_empty got empty=%b rptr=%0d ready=%b exp 1 0 1", oitf_empty, ret_ptr, dis_ready); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        push(32'h0000_0100, 5'd1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            pc = 32'h0000_0200 + 32'(4 * k); rdidx = 5'(k + 2); rdwen = 1'b1;
            dis_ena = 1'b1; ret_ena = 1'b1;
            tick();
            exp_pc = 32'h0000_0200 + 32'(4 * k);
            checks++; if (oitf_empty !== 1'b0 || dis_ready !== 1'b1) begin
                errors++; $display("FAIL wrap%0d_flags got empty=%b ready=%b exp 0 1", k, oitf_empty, dis_ready); end
            checks++; if (ret_ptr !== 1'((k + 1) % 2) || dis_ptr !== 1'((k + 2) % 2)) begin
                errors++; $display("FAIL wrap%0d_ptr got rptr=%0d dptr=%0d exp %0d %0d", k, ret_ptr, dis_ptr, (k + 1) % 2, (k + 2) % 2); end
            checks++; if (ret_pc !== exp_pc) begin
                errors++; $display("FAIL wrap%0d_pc got %h exp %h", k, ret_pc, exp_pc); end
        end
        dis_ena = 1'b0; ret_ena = 1'b0; rdwen = 1'b0;
        push(32'h0000_0300, 5'd9, 1'b1);
        checks++; if (dis_ready !== 1'b0 || ret_pc !== 32'h0000_021C) begin
            errors++; $display("FAIL wrap_full got ready=%b pc=%h exp 0 0000021c", dis_ready, ret_pc); end
        pc = 32'h0000_0400; rdidx = 5'd11; rdwen = 1'b1; dis_ena = 1'b1; ret_ena = 1'b1;
        tick();
        dis_ena = 1'b0; ret_ena = 1'b0; rdwen = 1'b0;
        checks++; if (dis_ready !== 1'b1 || dis_ptr !== 1'b0 || ret_ptr !== 1'b1 || ret_pc !== 32'h0000_0300) begin
            errors++; $display("FAIL full_pushpop got ready=%b dptr=%0d rptr=%0d pc=%h exp 1 0 1 00000300", dis_ready, dis_ptr, ret_ptr, ret_pc); end
        pop();
        checks++; if (oitf_empty !== 1'b1 || ret_ptr !== 1'b0) begin
            errors++; $display("FAIL full_pushpop_drain got empty=%b rptr=%0d exp 1 0", oitf_empty, ret_ptr); end
    endtask

    task automatic test_hazard();
        rs1en = 1'b1; rs1idx = 5'd10; rs1fpu = 1'b0;
        pc = 32'h0000_0500; rdidx = 5'd10; rdwen = 1'b1; rdfpu = 1'b0; dis_ena = 1'b1;
        #1;
        checks++; if (m_rs1 !== 1'b0 || m_rd !== 1'b0) begin
            errors++; $display("FAIL hz_self got rs1=%b rd=%b exp 0 0", m_rs1, m_rd); end
        tick();
        dis_ena = 1'b0; rdwen = 1'b0; rdidx = 5'd0;
        checks++; if (m_rs1 !== 1'b1) begin errors++; $display("FAIL hz_rs1 got %b exp 1", m_rs1); end
        rs1fpu = 1'b1; #1;
        checks++; if (m_rs1 !== 1'b0) begin errors++; $display("FAIL hz_rs1_fpu got %b exp 0", m_rs1); end
        rs1fpu = 1'b0;
        rs2en = 1'b0; rs2idx = 5'd10; #1;
        checks++; if (m_rs2 !== 1'b0) begin errors++; $display("FAIL hz_rs2_off got %b exp 0", m_rs2); end
        rs2en = 1'b1; rs3en = 1'b1; rs3idx = 5'd10; rdwen = 1'b1; rdidx = 5'd10; #1;
        checks++; if ({m_rs2, m_rs3, m_rd} !== 3'b111) begin
            errors++; $display("FAIL hz_rs2_rs3_rd got %b exp 111", {m_rs2, m_rs3, m_rd}); end
        rs3idx = 5'd11; rdwen = 1'b0; #1;
        checks++; if ({m_rs3, m_rd} !== 2'b00) begin
            errors++; $display("FAIL hz_miss got %b exp 00", {m_rs3, m_rd}); end
        rs2en = 1'b0; rs3en = 1'b0; rdidx = 5'd0;
        ret_ena = 1'b1; #1;
        checks++; if (m_rs1 !== 1'b1 || ret_pc !== 32'h0000_0500) begin
            errors++; $display("FAIL hz_pop_cycle got m=%b pc=%h exp 1 00000500", m_rs1, ret_pc); end
        tick();
        ret_ena = 1'b0;
        checks++; if (m_rs1 !== 1'b0 || oitf_empty !== 1'b1) begin
            errors++; $display("FAIL hz_after_pop got m=%b empty=%b exp 0 1", m_rs1, oitf_empty); end
        push(32'h0000_0600, 5'd10, 1'b0);
        checks++; if (m_rs1 !== 1'b0 || oitf_empty !== 1'b0) begin
            errors++; $display("FAIL hz_nowen got m=%b empty=%b exp 0 0", m_rs1, oitf_empty); end
        pop();
        rs1en = 1'b0; rs1idx = 5'd0;
    endtask

    task automatic test_reset_mid();
        push(32'h0000_0A00, 5'd12, 1'b1);
        push(32'h0000_0A04, 5'd13, 1'b1);
        checks++; if (dis_ready !== 1'b0) begin errors++; $display("FAIL mid_full got %b exp 0", dis_ready); end
        rs1en = 1'b1; rs1idx = 5'd12;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (oitf_empty !== 1'b1 || dis_ready !== 1'b1 || dis_ptr !== 1'b0 || ret_ptr !== 1'b0) begin
            errors++; $display("FAIL mid_rst got empty=%b ready=%b dptr=%0d rptr=%0d exp 1 1 0 0", oitf_empty, dis_ready, dis_ptr, ret_ptr); end
        checks++; if (ret_pc !== 32'd0 || ret_rdidx !== 5'd0 || m_rs1 !== 1'b0) begin
            errors++; $display("FAIL mid_rst_data got pc=%h rd=%0d m=%b exp 0 0 0", ret_pc, ret_rdidx, m_rs1); end
        #2 rst_n = 1'b1;
        rs1en = 1'b0;
        tick();
        checks++; if (dis_ptr !== 1'b0) begin errors++; $display("FAIL mid_dptr got %0d exp 0", dis_ptr); end
        push(32'h0000_0700, 5'd3, 1'b1);
        checks++; if (ret_pc !== 32'h0000_0700 || ret_ptr !== 1'b0 || dis_ptr !== 1'b1 || ret_rdidx !== 5'd3) begin
            errors++; $display("FAIL mid_push got pc=%h rptr=%0d dptr=%0d rd=%0d exp 00000700 0 1 3", ret_pc, ret_ptr, dis_ptr, ret_rdidx); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_retire();
        test_wrap();
        test_hazard();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
